// File: rtl/fragment_hazard_scheduler.sv
// Fragment hazard scheduler: stalls a fragment whose framebuffer index matches an
// in-flight write, retiring scoreboard entries in order on fragmentProcessed.

module fhs_entry #(
  parameter int IW   = 14,
  parameter int PW   = 3,
  parameter int SLOT = 0
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          wr_en,
  input  logic          clr,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_vld,
  input  logic [PW-1:0] rd_ptr,
  input  logic [PW:0]   count,
  input  logic [IW-1:0] q_idx,
  output logic          hit
);
  typedef struct packed {
    logic [IW-1:0] idx;
    logic          vld;
  } ent_t;

  ent_t          ent;
  logic [PW-1:0] ofs;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ent <= '0;
    end else if (wr_en) begin
      ent <= '{idx: wr_idx, vld: wr_vld};
    end else if (clr) begin
      ent.vld <= 1'b0;
    end
  end

  // Slot is live when its distance from rd_ptr (mod depth) is below count.
  assign ofs = PW'(SLOT) - rd_ptr;
  assign hit = ent.vld & ({1'b0, ofs} < count) & (ent.idx == q_idx);
endmodule

module fragment_hazard_scheduler #(
  parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
  parameter int KEEP_WIDTH              = 1,
  parameter int PAYLOAD_WIDTH           = 64,
  parameter int MAX_INFLIGHT            = 8,
  parameter int STALL_CNT_WIDTH         = 32
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic                               confHazardEnable,
  input  logic                               s_frag_tvalid,
  output logic                               s_frag_tready,
  input  logic                               s_frag_tlast,
  input  logic [KEEP_WIDTH-1:0]              s_frag_tkeep,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_frag_tindex,
  input  logic [PAYLOAD_WIDTH-1:0]           s_frag_tpayload,
  output logic                               m_frag_tvalid,
  input  logic                               m_frag_tready,
  output logic                               m_frag_tlast,
  output logic [KEEP_WIDTH-1:0]              m_frag_tkeep,
  output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_frag_tindex,
  output logic [PAYLOAD_WIDTH-1:0]           m_frag_tpayload,
  input  logic                               fragmentProcessed,
  output logic                               idle,
  output logic                               underflow,
  output logic [STALL_CNT_WIDTH-1:0]         stallCycles
);
  localparam int PW = $clog2(MAX_INFLIGHT);

  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [PW:0]             count;
  logic [MAX_INFLIGHT-1:0] hit_vec;
  logic                    keep_any, hit, full, stall, push, pop;

  assign keep_any = |s_frag_tkeep;
  assign hit      = |hit_vec;
  assign full     = (count == (PW+1)'(MAX_INFLIGHT));
  assign stall    = full | (confHazardEnable & keep_any & hit);

  assign s_frag_tready   = m_frag_tready & ~stall;
  assign m_frag_tvalid   = s_frag_tvalid & ~stall;
  assign m_frag_tlast    = s_frag_tlast;
  assign m_frag_tkeep    = s_frag_tkeep;
  assign m_frag_tindex   = s_frag_tindex;
  assign m_frag_tpayload = s_frag_tpayload;

  assign push = s_frag_tvalid & s_frag_tready;
  assign pop  = fragmentProcessed & (count != '0);
  assign idle = (count == '0);

  // Hits are taken from pre-pop state, so a retiring entry still blocks this cycle.
  for (genvar i = 0; i < MAX_INFLIGHT; i++) begin : g_ent
    fhs_entry #(.IW(FRAMEBUFFER_INDEX_WIDTH), .PW(PW), .SLOT(i)) u_ent (
      .aclk   (aclk),
      .areset (areset),
      .wr_en  (push & (wr_ptr == PW'(i))),
      .clr    (pop & (rd_ptr == PW'(i))),
      .wr_idx (s_frag_tindex),
      .wr_vld (keep_any),
      .rd_ptr (rd_ptr),
      .count  (count),
      .q_idx  (s_frag_tindex),
      .hit    (hit_vec[i])
    );
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      underflow   <= 1'b0;
      stallCycles <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (fragmentProcessed && count == '0) underflow <= 1'b1;
      if (s_frag_tvalid && m_frag_tready && stall && stallCycles != '1)
        stallCycles <= stallCycles + STALL_CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_fragment_hazard_scheduler.sv
// Directed bench for fragment_hazard_scheduler: queue-based scoreboard model checked
// every cycle, plus literal checkpoints from the hand-worked scenarios.

module tb_fragment_hazard_scheduler;
  localparam int IW = 14, KW = 1, PLW = 64, D = 8, SW = 32;

  logic           aclk = 1'b0, areset = 1'b1;
  logic           en = 1'b1, s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1, fp = 1'b0;
  logic [KW-1:0]  s_tkeep = '0;
  logic [IW-1:0]  s_tindex = '0;
  logic [PLW-1:0] s_tpayload = '0;
  logic           s_tready, m_tvalid, m_tlast, idle, underflow;
  logic [KW-1:0]  m_tkeep;
  logic [IW-1:0]  m_tindex;
  logic [PLW-1:0] m_tpayload;
  logic [SW-1:0]  stall_cycles;

  fragment_hazard_scheduler #(
    .FRAMEBUFFER_INDEX_WIDTH(IW), .KEEP_WIDTH(KW), .PAYLOAD_WIDTH(PLW),
    .MAX_INFLIGHT(D), .STALL_CNT_WIDTH(SW)
  ) dut (
    .aclk(aclk), .areset(areset), .confHazardEnable(en),
    .s_frag_tvalid(s_tvalid), .s_frag_tready(s_tready), .s_frag_tlast(s_tlast),
    .s_frag_tkeep(s_tkeep), .s_frag_tindex(s_tindex), .s_frag_tpayload(s_tpayload),
    .m_frag_tvalid(m_tvalid), .m_frag_tready(m_tready), .m_frag_tlast(m_tlast),
    .m_frag_tkeep(m_tkeep), .m_frag_tindex(m_tindex), .m_frag_tpayload(m_tpayload),
    .fragmentProcessed(fp), .idle(idle), .underflow(underflow), .stallCycles(stall_cycles)
  );

  always #5 aclk = ~aclk;

  int total = 0, bad = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard model: in-order list of in-flight fragments.
  typedef struct { logic [IW-1:0] idx; bit wr; } frag_t;
  frag_t       mq[$];
  bit          m_under;
  logic [SW-1:0] m_stall;

  function automatic bit m_stall_now();
    bit h = 0;
    foreach (mq[k]) if (mq[k].wr && mq[k].idx == s_tindex) h = 1;
    return (mq.size() == D) || (en && (|s_tkeep) && h);
  endfunction

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      mq.delete(); m_under = 0; m_stall = '0;
    end else begin
      bit st, acc, ret;
      st  = m_stall_now();
      acc = s_tvalid && m_tready && !st;
      ret = fp && mq.size() > 0;
      if (fp && mq.size() == 0) m_under = 1;
      if (s_tvalid && m_tready && st && m_stall != '1) m_stall = m_stall + 1;
      if (ret) void'(mq.pop_front());
      if (acc) mq.push_back('{idx: s_tindex, wr: |s_tkeep});
    end
  end

  always @(negedge aclk) if (started) begin
    bit st;
    st = m_stall_now();
    chk("s_tready", s_tready, m_tready && !st);
    chk("m_tvalid", m_tvalid, s_tvalid && !st);
    chk("m_tindex", m_tindex, s_tindex);
    chk("m_tkeep", m_tkeep, s_tkeep);
    chk("m_tlast", m_tlast, s_tlast);
    chk("m_tpayload", m_tpayload, s_tpayload);
    chk("idle", idle, mq.size() == 0);
    chk("underflow", underflow, m_under);
    chk("stallCycles", stall_cycles, m_stall);
  end

  task automatic tick(); @(posedge aclk); #1; endtask

  task automatic present(input int idx, input bit keep);
    s_tvalid = 1'b1; s_tindex = IW'(idx); s_tkeep = KW'(keep);
    s_tlast = idx[0]; s_tpayload = 64'hA5A5_0000_0000_0000 | 64'(idx);
  endtask

  task automatic retire(input int n);
    s_tvalid = 1'b0; fp = 1'b1;
    repeat (n) tick();
    fp = 1'b0;
  endtask

  initial begin
    tick(); tick();
    areset = 1'b0; started = 1;
    chk("rst_idle", idle, 1'b1);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_tready", s_tready, 1'b1);

    // RAW hazard on index 5: accept, then stall until retire
    present(5, 1); tick();
    repeat (3) begin chk("raw_stall", s_tready, 1'b0); tick(); end
    fp = 1'b1; chk("raw_stall_retire", s_tready, 1'b0); tick(); fp = 1'b0;
    chk("raw_release", s_tready, 1'b1);
    chk("raw_stallcnt", stall_cycles, 4);
    tick(); retire(1);
    chk("raw_idle", idle, 1'b1);

    // Fill to capacity, index 8 waits on full
    for (int i = 0; i < D; i++) begin present(i, 1); tick(); end
    present(8, 1);
    chk("full_stall", s_tready, 1'b0);
    chk("full_idle", idle, 1'b0);
    tick();
    fp = 1'b1; tick(); fp = 1'b0;
    chk("full_release", s_tready, 1'b1);
    tick();
    present(100, 1);
    chk("full_again", s_tready, 1'b0);
    s_tvalid = 1'b0;
    chk("full_stallcnt", stall_cycles, 6);
    retire(D);
    chk("full_drained", idle, 1'b1);

    // keep=0 never creates a hazard
    present(5, 0); tick();
    present(5, 1); chk("keep0_tready", s_tready, 1'b1); tick();
    s_tvalid = 1'b0; chk("keep0_notidle", idle, 1'b0);
    retire(2); chk("keep0_idle", idle, 1'b1);

    // Hazard check disabled
    en = 1'b0;
    present(3, 1); tick();
    chk("dis_tready", s_tready, 1'b1); tick();
    retire(2); chk("dis_idle", idle, 1'b1);
    en = 1'b1;

    // Retire in the same cycle a matching fragment is presented
    present(3, 1); tick();
    fp = 1'b1; chk("same_cyc_stall", s_tready, 1'b0); tick(); fp = 1'b0;
    chk("same_cyc_release", s_tready, 1'b1); tick();
    chk("same_cyc_stallcnt", stall_cycles, 7);
    retire(1);

    // Underflow, and backpressure without stall counting
    retire(1);
    chk("uf_flag", underflow, 1'b1);
    chk("uf_idle", idle, 1'b1);
    m_tready = 1'b0; present(9, 1); tick(); tick();
    chk("bp_stallcnt", stall_cycles, 7);
    chk("bp_idle", idle, 1'b1);
    m_tready = 1'b1; tick();
    present(10, 1); tick();
    chk("mid_notidle", idle, 1'b0);

    // Asynchronous reset mid-stream
    s_tvalid = 1'b0; areset = 1'b1; #1;
    chk("arst_idle", idle, 1'b1);
    chk("arst_underflow", underflow, 1'b0);
    chk("arst_stall", stall_cycles, 0);
    tick(); areset = 1'b0;
    present(9, 1); tick(); s_tvalid = 1'b0;
    chk("post_rst_push", idle, 1'b0);
    retire(1);
    chk("post_rst_idle", idle, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fragment_hazard_scheduler.md
Name: fragment_hazard_scheduler

Overview:
Sits between the rasterizer/texture stage and the framebuffer-read plus per-fragment (blend/test/writeback) pipeline. Tracks the framebuffer indices of fragments in flight and stalls a new fragment whose index matches an in-flight write. This prevents read-after-write hazards on colour, depth and stencil. Completion is signalled by the per-fragment pipeline's fragmentProcessed pulse, which retires fragments in order.

Parameters:
FRAMEBUFFER_INDEX_WIDTH, 14, width of framebuffer index
KEEP_WIDTH, 1, width of tkeep
PAYLOAD_WIDTH, 64, opaque fragment payload passed through unchanged
MAX_INFLIGHT, 8, scoreboard depth; power of two, >= 2
STALL_CNT_WIDTH, 32, width of stall statistics counter

Ports:
aclk  in  1  clock
areset  in  1  reset; one clock; reset is asynchronous and active-high
confHazardEnable  in  1  1 = index hazard check active
s_frag_tvalid  in  1  upstream valid
s_frag_tready  out  1  upstream ready
s_frag_tlast  in  1  last fragment of primitive
s_frag_tkeep  in  KEEP_WIDTH  fragment writes framebuffer
s_frag_tindex  in  FRAMEBUFFER_INDEX_WIDTH  framebuffer index
s_frag_tpayload  in  PAYLOAD_WIDTH  opaque data
m_frag_tvalid  out  1  downstream valid
m_frag_tready  in  1  downstream ready
m_frag_tlast  out  1  pass-through of s_frag_tlast
m_frag_tkeep  out  KEEP_WIDTH  pass-through
m_frag_tindex  out  FRAMEBUFFER_INDEX_WIDTH  pass-through
m_frag_tpayload  out  PAYLOAD_WIDTH  pass-through
fragmentProcessed  in  1  one-cycle pulse: oldest in-flight fragment retired
idle  out  1  scoreboard empty
underflow  out  1  sticky: retire pulse seen while empty
stallCycles  out  STALL_CNT_WIDTH  saturating stall counter

Behaviour:
- Storage: circular buffer of MAX_INFLIGHT entries {index, valid}; rdPtr, wrPtr (log2 MAX_INFLIGHT bits, wrap modulo depth); count (0..MAX_INFLIGHT).
- An entry is live if it lies in [rdPtr, rdPtr+count). Entry valid = |s_frag_tkeep at push.
- hit: any live entry with valid=1 and index == s_frag_tindex. Compare is combinational against registered state.
- full = (count == MAX_INFLIGHT).
- stall = full | (confHazardEnable & |s_frag_tkeep & hit).
- Handshake is a combinational pass-through. s_frag_tready = m_frag_tready & ~stall. m_frag_tvalid = s_frag_tvalid & ~stall. All m_frag_t* data equals the s_frag_t* data. Zero latency.
- Push on s_frag_tvalid & s_frag_tready: write {tindex, |tkeep} at wrPtr, then wrPtr+1. Every accepted fragment is pushed, including keep=0, because the downstream pulses fragmentProcessed for every fragment.
- Pop on fragmentProcessed & count>0: clear valid at rdPtr, then rdPtr+1.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Hit/full are evaluated against pre-pop state. An entry retiring this cycle still blocks; the stalled fragment is accepted the following cycle.
- fragmentProcessed while count==0: no pointer change; underflow <= 1 and stays 1 until reset.
- confHazardEnable=0: no index stall, but the full stall and bookkeeping remain active.
- idle = (count == 0), registered-state derived.
- stallCycles: +1 each cycle s_frag_tvalid & m_frag_tready & stall; saturates at all-ones.
- Reset (async assert, any time including mid-operation) sets:
  - rdPtr = wrPtr = count = 0, all valid = 0
  - underflow = 0, stallCycles = 0, idle = 1
  - s_frag_tready follows m_frag_tready
- The downstream pipeline must be reset together with this block; a retire pulse from a pre-reset fragment sets underflow.

Test Plan:
- Accept index 5 (keep=1), present index 5 next cycle, no retire -> s_frag_tready=0 each cycle. Pulse fragmentProcessed at cycle N -> second fragment accepted at N+1; stallCycles = number of waiting cycles.
- MAX_INFLIGHT=8: indices 0..7 back-to-back, no retire -> 8 accepted, index 8 stalls (full), idle=0. One retire -> index 8 accepted next cycle, count=8.
- Index 5 with keep=0, then index 5 with keep=1 -> both accepted consecutively; count=2.
- confHazardEnable=0: index 3 twice back-to-back -> no stall, count=2. Two retires -> idle=1.
- Index 3 in flight; present index 3 in the same cycle fragmentProcessed pops it -> stall that cycle, accept next cycle; stallCycles=1.
- fragmentProcessed with count=0 -> underflow=1, count stays 0. m_frag_tready=0 with s_frag_tvalid=1 -> no push, stallCycles unchanged. Assert areset mid-stream -> idle=1, underflow=0.
